mcycle_ctrl: RTL and testbench

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

---
 rtl/mc_pkg.sv | 80 ++++++++
 rtl/mc_outdec.sv | 81 ++++++++
 rtl/mcycle_ctrl.sv | 111 +++++++++++
 tb/tb_mcycle_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller and the ALU control unit.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package mc_pkg;

    // Controller state codes; the numeric values are visible on the state port.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Primary opcodes, instruction[31:26].
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Request to the ALU control unit; FUNCT means "look at the funct field".
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    // ALU operand B select.
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // All datapath controls driven by the controller in one bundle.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        alu_op_t    alu_op;
    } ctrl_t;

    // Opcodes the controller knows how to sequence.
    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

    // True when the current state ends an instruction on this cycle's edge.
    function automatic logic is_retire(input state_t s, input logic mem_ready);
        case (s)
            S_MEMWB, S_RWB, S_BRANCH, S_ADDIWB, S_JUMP: return 1'b1;
            S_MEMWR:                                    return mem_ready;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational decode of controller state into datapath control strobes.
// Latency: zero cycles (pure combinational).
// Backpressure: mem_ready gates the FETCH-cycle IR and PC writes; rst forces every output low.
module mc_outdec
    import mc_pkg::*;
(
    input  state_t      st,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    input  logic        rst,
    output ctrl_t       ctrl,
    output logic        illegal
);

    // Per-state control pattern; anything not set for a state stays 0.
    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        // Reset kills strobes combinationally so nothing leaks out mid-abort.
        if (!rst) begin
            case (st)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH2;
                    ctrl.alu_op    = ALU_ADD;
                    illegal        = !op_known(opcode);
                end
                S_MEMADR, S_ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_RWB: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                S_BRANCH: begin
                    // The zero flag qualifies the PC write in the datapath.
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REG;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                S_ADDIWB: begin
                    ctrl.reg_write = 1'b1;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS-subset main controller with retired-instruction counter.
// Latency: 3-5 cycles per instruction with memory ready; abort on rst is immediate.
// Backpressure: mem_ready=0 holds FETCH, MEMRD and MEMWR one extra cycle each.
module mcycle_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    ctrl_t            ctrl;

    // The branch decision is taken in the datapath; the flag is accepted but not consumed.
    logic unused_zero;
    assign unused_zero = zero;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state sequencing; unknown codes fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              count_q <= '0;
        else if (is_retire(state_q, mem_ready)) count_q <= count_q + CNT_W'(1);
    end

    // Output decode lives in its own combinational block.
    mc_outdec u_outdec (
        .st        (state_q),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .rst       (rst),
        .ctrl      (ctrl),
        .illegal   (illegal)
    );

    // Flatten the control bundle onto the datapath ports.
    always_comb begin
        PCWrite     = ctrl.pc_write;
        PCWriteCond = ctrl.pc_write_cond;
        IorD        = ctrl.i_or_d;
        MemRead     = ctrl.mem_read;
        MemWrite    = ctrl.mem_write;
        IRWrite     = ctrl.ir_write;
        MemtoReg    = ctrl.mem_to_reg;
        RegDst      = ctrl.reg_dst;
        RegWrite    = ctrl.reg_write;
        ALUSrcA     = ctrl.alu_src_a;
        ALUSrcB     = ctrl.alu_src_b;
        PCSource    = ctrl.pc_source;
        ALUOp       = ctrl.alu_op;
        state       = state_q;
        instr_count = count_q;
    end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed table-driven bench for mcycle_ctrl plus reset-abort and counter-wrap sequences.
// Latency: checks one vector per clock cycle.
// Backpressure: mem_ready is driven per vector to exercise wait states.
module tb_mcycle_ctrl;

    // Expected control words: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
    //  MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB[1:0],PCSource[1:0],ALUOp[1:0]}
    localparam logic [15:0] C_RST    = 16'h0000;
    localparam logic [15:0] C_FETCH  = 16'h9410;
    localparam logic [15:0] C_FWAIT  = 16'h1010;
    localparam logic [15:0] C_DECODE = 16'h0030;
    localparam logic [15:0] C_MEMADR = 16'h0060;
    localparam logic [15:0] C_MEMRD  = 16'h3000;
    localparam logic [15:0] C_MEMWB  = 16'h0280;
    localparam logic [15:0] C_MEMWR  = 16'h2800;
    localparam logic [15:0] C_EXEC   = 16'h0042;
    localparam logic [15:0] C_RWB    = 16'h0180;
    localparam logic [15:0] C_BRANCH = 16'h4045;
    localparam logic [15:0] C_ADDIWB = 16'h0080;
    localparam logic [15:0] C_JUMP   = 16'h8008;

    localparam logic [5:0] O_R    = 6'b000000;
    localparam logic [5:0] O_LW   = 6'b100011;
    localparam logic [5:0] O_SW   = 6'b101011;
    localparam logic [5:0] O_BEQ  = 6'b000100;
    localparam logic [5:0] O_ADDI = 6'b001000;
    localparam logic [5:0] O_J    = 6'b000010;
    localparam logic [5:0] O_BAD  = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  opc;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
        logic [31:0] cnt;
    } vec_t;

    logic clk, rst, zero, mem_ready;
    logic [5:0] opcode;

    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic [3:0] state;
    logic illegal;
    logic [31:0] instr_count;

    logic w_PCWrite, w_PCWriteCond, w_IorD, w_MemRead, w_MemWrite, w_IRWrite;
    logic w_MemtoReg, w_RegDst, w_RegWrite, w_ALUSrcA;
    logic [1:0] w_ALUSrcB, w_PCSource, w_ALUOp;
    logic [3:0] w_state;
    logic w_illegal;
    logic [3:0] w_instr_count;

    logic [15:0] act_ctl;
    assign act_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                      MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp};

    mcycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .state(state), .illegal(illegal), .instr_count(instr_count)
    );

    mcycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(w_PCWrite), .PCWriteCond(w_PCWriteCond), .IorD(w_IorD), .MemRead(w_MemRead),
        .MemWrite(w_MemWrite), .IRWrite(w_IRWrite), .MemtoReg(w_MemtoReg), .RegDst(w_RegDst),
        .RegWrite(w_RegWrite), .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB), .PCSource(w_PCSource),
        .ALUOp(w_ALUOp), .state(w_state), .illegal(w_illegal), .instr_count(w_instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;
    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] o, input logic z, input logic m,
                       input logic [3:0] s, input logic [15:0] c, input logic i,
                       input logic [31:0] n);
        vec_t v;
        v.rst = r; v.opc = o; v.zero = z; v.rdy = m;
        v.st = s; v.ctl = c; v.ill = i; v.cnt = n;
        tv.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = O_R; zero = 1'b0; mem_ready = 1'b1;

        // reset
        add(1, O_R,    0, 1, 4'd0,  C_RST,    0, 0);
        // add: 0,1,6,7
        add(0, O_R,    0, 1, 4'd0,  C_FETCH,  0, 0);
        add(0, O_R,    0, 1, 4'd1,  C_DECODE, 0, 0);
        add(0, O_R,    0, 1, 4'd6,  C_EXEC,   0, 0);
        add(0, O_R,    0, 1, 4'd7,  C_RWB,    0, 0);
        // lw with two wait cycles in MEMRD
        add(0, O_LW,   0, 1, 4'd0,  C_FETCH,  0, 1);
        add(0, O_LW,   0, 1, 4'd1,  C_DECODE, 0, 1);
        add(0, O_LW,   0, 1, 4'd2,  C_MEMADR, 0, 1);
        add(0, O_LW,   0, 0, 4'd3,  C_MEMRD,  0, 1);
        add(0, O_LW,   0, 0, 4'd3,  C_MEMRD,  0, 1);
        add(0, O_LW,   0, 1, 4'd3,  C_MEMRD,  0, 1);
        add(0, O_LW,   0, 1, 4'd4,  C_MEMWB,  0, 1);
        // sw with a FETCH wait and a MEMWR wait
        add(0, O_SW,   0, 0, 4'd0,  C_FWAIT,  0, 2);
        add(0, O_SW,   0, 1, 4'd0,  C_FETCH,  0, 2);
        add(0, O_SW,   0, 1, 4'd1,  C_DECODE, 0, 2);
        add(0, O_SW,   0, 1, 4'd2,  C_MEMADR, 0, 2);
        add(0, O_SW,   0, 0, 4'd5,  C_MEMWR,  0, 2);
        add(0, O_SW,   0, 1, 4'd5,  C_MEMWR,  0, 2);
        // beq, zero=1 then zero=0; both retire
        add(0, O_BEQ,  1, 1, 4'd0,  C_FETCH,  0, 3);
        add(0, O_BEQ,  1, 1, 4'd1,  C_DECODE, 0, 3);
        add(0, O_BEQ,  1, 1, 4'd8,  C_BRANCH, 0, 3);
        add(0, O_BEQ,  0, 1, 4'd0,  C_FETCH,  0, 4);
        add(0, O_BEQ,  0, 1, 4'd1,  C_DECODE, 0, 4);
        add(0, O_BEQ,  0, 1, 4'd8,  C_BRANCH, 0, 4);
        // illegal opcode: one-cycle pulse, no count
        add(0, O_BAD,  0, 1, 4'd0,  C_FETCH,  0, 5);
        add(0, O_BAD,  0, 1, 4'd1,  C_DECODE, 1, 5);
        // addi
        add(0, O_ADDI, 0, 1, 4'd0,  C_FETCH,  0, 5);
        add(0, O_ADDI, 0, 1, 4'd1,  C_DECODE, 0, 5);
        add(0, O_ADDI, 0, 1, 4'd9,  C_MEMADR, 0, 5);
        add(0, O_ADDI, 0, 1, 4'd10, C_ADDIWB, 0, 5);
        // j
        add(0, O_J,    0, 1, 4'd0,  C_FETCH,  0, 6);
        add(0, O_J,    0, 1, 4'd1,  C_DECODE, 0, 6);
        add(0, O_J,    0, 1, 4'd11, C_JUMP,   0, 6);
        add(0, O_R,    0, 1, 4'd0,  C_FETCH,  0, 7);

        for (int k = 0; k < tv.size(); k++) begin
            rst = tv[k].rst; opcode = tv[k].opc; zero = tv[k].zero; mem_ready = tv[k].rdy;
            #2;
            check($sformatf("v%0d_state", k), {28'd0, state}, {28'd0, tv[k].st});
            check($sformatf("v%0d_ctl", k), {16'd0, act_ctl}, {16'd0, tv[k].ctl});
            check($sformatf("v%0d_illegal", k), {31'd0, illegal}, {31'd0, tv[k].ill});
            check($sformatf("v%0d_count", k), instr_count, tv[k].cnt);
            check($sformatf("v%0d_count4", k), {28'd0, w_instr_count}, {28'd0, tv[k].cnt[3:0]});
            step();
        end

        // Reset while waiting in MEMWR: strobe must drop in the same cycle.
        opcode = O_SW;          // now in DECODE
        step();                 // MEMADR
        step();                 // MEMWR
        mem_ready = 1'b0;
        #2;
        check("memwr_wait_state", {28'd0, state}, 32'd5);
        check("memwr_wait_memwrite", {31'd0, MemWrite}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_memwrite", {31'd0, MemWrite}, 32'd0);
        check("abort_state", {28'd0, state}, 32'd0);
        check("abort_count", instr_count, 32'd0);
        check("abort_ctl", {16'd0, act_ctl}, {16'd0, C_RST});
        step();
        check("rst_hold_ctl", {16'd0, act_ctl}, {16'd0, C_RST});
        rst = 1'b0; mem_ready = 1'b1; opcode = O_R;
        #2;
        check("post_rst_state", {28'd0, state}, 32'd0);
        check("post_rst_ctl", {16'd0, act_ctl}, {16'd0, C_FETCH});
        step();

        // Counter wrap: 16 jumps on the 4-bit instance, 3 cycles each.
        rst = 1'b1;
        step();
        rst = 1'b0; opcode = O_J; mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #2;
            check($sformatf("j%0d_fetch", i), {28'd0, w_state}, 32'd0);
            check($sformatf("j%0d_count4", i), {28'd0, w_instr_count}, {28'd0, 4'(i)});
            step();
            check($sformatf("j%0d_decode", i), {28'd0, w_state}, 32'd1);
            step();
            check($sformatf("j%0d_jump", i), {28'd0, w_state}, 32'd11);
            check($sformatf("j%0d_pcsrc", i), {30'd0, w_PCSource}, 32'd2);
            check($sformatf("j%0d_pcwrite", i), {31'd0, w_PCWrite}, 32'd1);
            step();
        end
        #2;
        check("wrap_state", {28'd0, w_state}, 32'd0);
        check("wrap_count4", {28'd0, w_instr_count}, 32'd0);
        check("wrap_count32", instr_count, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
